// File: rtl/lcd_rgb_rx.sv
// Panel-side receiver for the 16-bit parallel RGB LCD bus: oversamples the bus on sys_clk,
// emits a coordinate-tagged pixel stream and measures the active resolution of each frame.
`timescale 1ns/1ps
module lcd_rgb_rx #(
  parameter int          X_W      = 11,
  parameter int          Y_W      = 11,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [15:0] PANEL_ID = 16'h0010
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           lcd_clk,
  input  logic           lcd_de,
  input  logic           lcd_hs,
  input  logic           lcd_vs,
  input  logic [15:0]    lcd_rgb_in,
  output logic           lcd_rgb_id_oe,
  output logic [15:0]    lcd_rgb_id,
  output logic           pix_valid,
  output logic [15:0]    pix_data,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_start,
  output logic           line_end,
  output logic           frame_done,
  output logic [X_W-1:0] h_active,
  output logic [Y_W-1:0] v_active,
  output logic           meas_valid,
  output logic           err_line_len
);

  localparam int PIN_W    = 20;
  localparam int PIN_CLK  = 19;
  localparam int PIN_DE   = 18;
  localparam int PIN_HS   = 17;
  localparam int PIN_VS   = 16;

  localparam logic [1:0] ST_WAIT_VS = 2'd0;
  localparam logic [1:0] ST_V_BLANK = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_H_BLANK = 2'd3;

  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;

  logic [PIN_W-1:0] pins;
  logic [PIN_W-1:0] pins_sync;

  assign pins = {lcd_clk, lcd_de, lcd_hs, lcd_vs, lcd_rgb_in};

  // Every pin gets the same two-flop synchronizer so bus and clock stay aligned.
  genvar gi;
  generate
    for (gi = 0; gi < PIN_W; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= pins[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pins_sync[gi] = sync_reg;
    end
  endgenerate

  logic        clk_d_reg;
  logic        sample_reg;
  logic        de_reg;
  logic        hs_reg;
  logic        vs_reg;
  logic [15:0] rgb_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_d_reg  <= 1'b0;
      sample_reg <= 1'b0;
      de_reg     <= 1'b0;
      hs_reg     <= 1'b0;
      vs_reg     <= 1'b0;
      rgb_reg    <= '0;
    end else begin
      clk_d_reg  <= pins_sync[PIN_CLK];
      sample_reg <= pins_sync[PIN_CLK] & ~clk_d_reg;
      de_reg     <= pins_sync[PIN_DE];
      hs_reg     <= pins_sync[PIN_HS];
      vs_reg     <= pins_sync[PIN_VS];
      rgb_reg    <= pins_sync[15:0];
    end
  end

  // Lines are delimited by DE; HS is kept aligned with the bus but drives no decoding.
  logic hs_act_unused;
  assign hs_act_unused = (hs_reg == SYNC_POL);

  logic vs_act;
  logic vs_edge;
  logic vs_prev_reg, vs_prev_next;

  assign vs_act  = (vs_reg == SYNC_POL);
  assign vs_edge = sample_reg && vs_act && !vs_prev_reg;

  logic [1:0]     state_reg, state_next;
  logic [X_W-1:0] x_reg, x_next;
  logic [Y_W-1:0] y_reg, y_next;
  logic [X_W-1:0] ref_len_reg, ref_len_next;
  logic           ref_set_reg, ref_set_next;
  logic           err_pend_reg, err_pend_next;

  logic           pix_valid_reg, pix_valid_next;
  logic [15:0]    pix_data_reg, pix_data_next;
  logic [X_W-1:0] pix_x_reg, pix_x_next;
  logic [Y_W-1:0] pix_y_reg, pix_y_next;
  logic           frame_start_reg, frame_start_next;
  logic           line_end_reg, line_end_next;
  logic           frame_done_reg, frame_done_next;
  logic [X_W-1:0] h_active_reg, h_active_next;
  logic [Y_W-1:0] v_active_reg, v_active_next;
  logic           meas_valid_reg, meas_valid_next;
  logic           err_line_len_reg, err_line_len_next;

  always_comb begin
    state_next        = state_reg;
    x_next            = x_reg;
    y_next            = y_reg;
    ref_len_next      = ref_len_reg;
    ref_set_next      = ref_set_reg;
    err_pend_next     = err_pend_reg;
    vs_prev_next      = vs_prev_reg;
    pix_valid_next    = 1'b0;
    pix_data_next     = pix_data_reg;
    pix_x_next        = pix_x_reg;
    pix_y_next        = pix_y_reg;
    frame_start_next  = 1'b0;
    line_end_next     = 1'b0;
    frame_done_next   = 1'b0;
    h_active_next     = h_active_reg;
    v_active_next     = v_active_reg;
    meas_valid_next   = meas_valid_reg;
    err_line_len_next = err_line_len_reg;

    if (sample_reg) begin
      vs_prev_next = vs_act;
      if (state_reg == ST_WAIT_VS) begin
        if (vs_edge) begin
          state_next = ST_V_BLANK;
        end
      end else begin
        // A frame-closing VS takes priority over capturing a pixel on the same sample.
        if (de_reg && !vs_edge) begin
          pix_valid_next   = 1'b1;
          pix_data_next    = rgb_reg;
          pix_x_next       = x_reg;
          pix_y_next       = y_reg;
          frame_start_next = (x_reg == '0) && (y_reg == '0);
          if (x_reg == X_MAX) begin
            err_pend_next = 1'b1;
          end else begin
            x_next = x_reg + 1'b1;
          end
          state_next = ST_ACTIVE;
        end

        if ((state_reg == ST_ACTIVE) && (!de_reg || vs_edge)) begin
          line_end_next = 1'b1;
          x_next        = '0;
          if (y_reg == Y_MAX) begin
            err_pend_next = 1'b1;
          end else begin
            y_next = y_reg + 1'b1;
          end
          if (!ref_set_reg) begin
            ref_len_next = x_reg;
            ref_set_next = 1'b1;
          end else if (x_reg != ref_len_reg) begin
            err_pend_next = 1'b1;
          end
          if (de_reg) begin
            err_pend_next = 1'b1;
          end
          state_next = ST_H_BLANK;
        end

        if (vs_edge) begin
          frame_done_next   = 1'b1;
          v_active_next     = y_next;
          h_active_next     = ref_len_next;
          err_line_len_next = err_pend_next;
          meas_valid_next   = 1'b1;
          x_next            = '0;
          y_next            = '0;
          ref_len_next      = '0;
          ref_set_next      = 1'b0;
          err_pend_next     = 1'b0;
          state_next        = ST_V_BLANK;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg        <= ST_WAIT_VS;
      x_reg            <= '0;
      y_reg            <= '0;
      ref_len_reg      <= '0;
      ref_set_reg      <= 1'b0;
      err_pend_reg     <= 1'b0;
      // Treated as already active so a VS held through reset is not taken as an edge.
      vs_prev_reg      <= 1'b1;
      pix_valid_reg    <= 1'b0;
      pix_data_reg     <= '0;
      pix_x_reg        <= '0;
      pix_y_reg        <= '0;
      frame_start_reg  <= 1'b0;
      line_end_reg     <= 1'b0;
      frame_done_reg   <= 1'b0;
      h_active_reg     <= '0;
      v_active_reg     <= '0;
      meas_valid_reg   <= 1'b0;
      err_line_len_reg <= 1'b0;
      lcd_rgb_id_oe    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      x_reg            <= x_next;
      y_reg            <= y_next;
      ref_len_reg      <= ref_len_next;
      ref_set_reg      <= ref_set_next;
      err_pend_reg     <= err_pend_next;
      vs_prev_reg      <= vs_prev_next;
      pix_valid_reg    <= pix_valid_next;
      pix_data_reg     <= pix_data_next;
      pix_x_reg        <= pix_x_next;
      pix_y_reg        <= pix_y_next;
      frame_start_reg  <= frame_start_next;
      line_end_reg     <= line_end_next;
      frame_done_reg   <= frame_done_next;
      h_active_reg     <= h_active_next;
      v_active_reg     <= v_active_next;
      meas_valid_reg   <= meas_valid_next;
      err_line_len_reg <= err_line_len_next;
      // Raw pin on purpose: the ID tristate must turn around with the driver's DE.
      lcd_rgb_id_oe    <= ~lcd_de;
    end
  end

  assign lcd_rgb_id   = PANEL_ID;
  assign pix_valid    = pix_valid_reg;
  assign pix_data     = pix_data_reg;
  assign pix_x        = pix_x_reg;
  assign pix_y        = pix_y_reg;
  assign frame_start  = frame_start_reg;
  assign line_end     = line_end_reg;
  assign frame_done   = frame_done_reg;
  assign h_active     = h_active_reg;
  assign v_active     = v_active_reg;
  assign meas_valid   = meas_valid_reg;
  assign err_line_len = err_line_len_reg;

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Scoreboard bench for lcd_rgb_rx: a frame-level model queues expected pixels and frame
// measurements as the LCD bus is driven; a monitor pops and compares on DUT strobes.
`timescale 1ns/1ps
module tb_lcd_rgb_rx;
  localparam int   X_W    = 11;
  localparam int   Y_W    = 11;
  localparam logic VS_ON  = 1'b0;
  localparam logic VS_OFF = 1'b1;
  localparam logic HS_ON  = 1'b0;
  localparam logic HS_OFF = 1'b1;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic           lcd_clk = 1'b0;
  logic           lcd_de = 1'b0;
  logic           lcd_hs = HS_OFF;
  logic           lcd_vs = VS_OFF;
  logic [15:0]    lcd_rgb_in = '0;
  logic           lcd_rgb_id_oe;
  logic [15:0]    lcd_rgb_id;
  logic           pix_valid;
  logic [15:0]    pix_data;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           frame_start, line_end, frame_done;
  logic [X_W-1:0] h_active;
  logic [Y_W-1:0] v_active;
  logic           meas_valid, err_line_len;

  always #5 sys_clk = ~sys_clk;

  lcd_rgb_rx #(.X_W(X_W), .Y_W(Y_W), .SYNC_POL(1'b0), .PANEL_ID(16'h0010)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lcd_clk(lcd_clk), .lcd_de(lcd_de),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_rgb_in(lcd_rgb_in),
    .lcd_rgb_id_oe(lcd_rgb_id_oe), .lcd_rgb_id(lcd_rgb_id), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .line_end(line_end), .frame_done(frame_done), .h_active(h_active), .v_active(v_active),
    .meas_valid(meas_valid), .err_line_len(err_line_len)
  );

  typedef struct packed {
    logic [15:0]    data;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           fs;
  } pix_t;

  typedef struct packed {
    logic [X_W-1:0] h;
    logic [Y_W-1:0] v;
    logic           err;
    logic           le;
  } close_t;

  pix_t   pix_q[$];
  close_t close_q[$];
  int     lens[$];
  bit     armed = 1'b0;
  int     le_exp = 0;
  int     le_seen = 0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Frame closes report the first line's width, the line count, and any width mismatch.
  function automatic void close_frame(input bit forced_err, input bit le);
    close_t c;
    c.h   = (lens.size() > 0) ? X_W'(lens[0]) : '0;
    c.v   = Y_W'(lens.size());
    c.err = forced_err;
    foreach (lens[i]) if (lens[i] != lens[0]) c.err = 1'b1;
    c.le  = le;
    close_q.push_back(c);
    lens.delete();
  endfunction

  // One lcd_clk period = 4 sys_clk; bus changes on the falling lcd_clk edge.
  task automatic lcd_cycle(input logic de, input logic hs, input logic vs, input logic [15:0] rgb);
    @(negedge sys_clk);
    lcd_clk = 1'b0; lcd_de = de; lcd_hs = hs; lcd_vs = vs; lcd_rgb_in = rgb;
    @(negedge sys_clk);
    @(negedge sys_clk);
    lcd_clk = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic send_vs(input int vbp);
    if (armed) close_frame(1'b0, 1'b0);
    armed = 1'b1;
    repeat (2) lcd_cycle(1'b0, HS_OFF, VS_ON, 16'h0);
    repeat (vbp) lcd_cycle(1'b0, HS_OFF, VS_OFF, 16'h0);
  endtask

  task automatic send_line(input int len, input int hbp, input bit yx_data, input bit cut);
    int y;
    logic [15:0] rgb;
    y = lens.size();
    lcd_cycle(1'b0, HS_ON, VS_OFF, 16'h0);
    repeat (hbp - 1) lcd_cycle(1'b0, HS_OFF, VS_OFF, 16'h0);
    for (int x = 0; x < len; x++) begin
      rgb = yx_data ? {y[7:0], x[7:0]} : 16'($urandom);
      if (armed) pix_q.push_back('{data: rgb, x: X_W'(x), y: Y_W'(y), fs: (x == 0 && y == 0)});
      lcd_cycle(1'b1, HS_OFF, VS_OFF, rgb);
    end
    if (cut) begin
      if (armed) begin
        lens.push_back(len);
        le_exp++;
        close_frame(1'b1, 1'b1);
      end
      armed = 1'b1;
      lcd_cycle(1'b1, HS_OFF, VS_ON, 16'($urandom));
      lcd_cycle(1'b0, HS_OFF, VS_ON, 16'h0);
      lcd_cycle(1'b0, HS_OFF, VS_OFF, 16'h0);
    end else begin
      if (armed) begin
        lens.push_back(len);
        le_exp++;
      end
      repeat (2) lcd_cycle(1'b0, HS_OFF, VS_OFF, 16'h0);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_flags"}, {pix_valid, frame_start, line_end, frame_done, meas_valid, err_line_len, lcd_rgb_id_oe}, 64'h0);
    chk({tag, "_pixel"}, {pix_data, pix_x, pix_y}, 64'h0);
    chk({tag, "_meas"}, {h_active, v_active}, 64'h0);
  endtask

  // Monitor: compares every DUT strobe against the head of the matching queue.
  initial begin
    pix_t   p;
    close_t c;
    forever begin
      @(posedge sys_clk);
      #1;
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_unexpected: got pixel x=%0d y=%0d, required no pixel", pix_x, pix_y);
        end else begin
          p = pix_q.pop_front();
          chk("pix_data", pix_data, p.data);
          chk("pix_x", pix_x, p.x);
          chk("pix_y", pix_y, p.y);
          chk("frame_start", frame_start, p.fs);
        end
      end
      if (line_end) le_seen++;
      if (frame_done) begin
        if (close_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got frame_done, required none");
        end else begin
          c = close_q.pop_front();
          $display("frame_done h_active=%0d v_active=%0d err_line_len=%0d (model %0d/%0d/%0d)",
                   h_active, v_active, err_line_len, c.h, c.v, c.err);
          chk("h_active", h_active, c.h);
          chk("v_active", v_active, c.v);
          chk("err_line_len", err_line_len, c.err);
          chk("meas_valid", meas_valid, 1);
          chk("line_end_with_close", line_end, c.le);
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge sys_clk);
    errors++;
    $display("FAIL watchdog: got no finish within 80000 cycles, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_oe;
    int   v, h, bad, len;

    repeat (3) @(posedge sys_clk);
    #1;
    check_idle("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // ID turnaround follows raw DE with one cycle of delay
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      lcd_de = 1'($urandom_range(0, 1));
      exp_oe = !lcd_de;
      @(posedge sys_clk);
      #1;
      $display("id de=%0d oe=%0d id=0x%04h", lcd_de, lcd_rgb_id_oe, lcd_rgb_id);
      chk("id_oe", lcd_rgb_id_oe, exp_oe);
      chk("id_word", lcd_rgb_id, 16'h0010);
    end
    lcd_de = 1'b0;

    // Mid-frame start: ignored until the first VS edge
    send_line(6, 2, 1'b0, 1'b0);
    send_line(6, 2, 1'b0, 1'b0);
    send_vs(2);
    chk("meas_valid_before_first_close", meas_valid, 0);

    // 8x4 frame, {y,x} pixels, HBP 3, VBP 2
    for (int l = 0; l < 4; l++) send_line(8, 3, 1'b1, 1'b0);
    send_vs(2);

    // Line 2 one pixel short, then a clean frame
    for (int l = 0; l < 4; l++) send_line((l == 2) ? 7 : 8, 3, 1'b0, 1'b0);
    send_vs(2);
    for (int l = 0; l < 4; l++) send_line(8, 3, 1'b0, 1'b0);
    send_vs(2);

    // Frame without any DE
    send_vs(2);

    // VS arrives while DE is high after 5 pixels
    send_line(6, 2, 1'b0, 1'b0);
    send_line(6, 2, 1'b0, 1'b0);
    send_line(5, 2, 1'b0, 1'b1);
    send_vs(1);

    // Randomized frames, some with a short or long line
    for (int f = 0; f < 5; f++) begin
      v   = $urandom_range(1, 4);
      h   = $urandom_range(2, 9);
      bad = $urandom_range(0, 2);
      for (int l = 0; l < v; l++) begin
        len = (bad == 1 && l == v - 1 && v > 1) ? h + 1 : h;
        send_line(len, $urandom_range(1, 4), 1'b0, 1'b0);
      end
      send_vs($urandom_range(1, 3));
    end

    // Reset mid-line: stop the pixel clock, let in-flight pixels drain, then reset
    lcd_cycle(1'b0, HS_ON, VS_OFF, 16'h0);
    for (int x = 0; x < 3; x++) begin
      logic [15:0] rgb;
      rgb = 16'($urandom);
      pix_q.push_back('{data: rgb, x: X_W'(x), y: Y_W'(lens.size()), fs: (x == 0 && lens.size() == 0)});
      lcd_cycle(1'b1, HS_OFF, VS_OFF, rgb);
    end
    repeat (8) @(negedge sys_clk);
    chk("pixels_drained_before_reset", pix_q.size(), 0);
    sys_rst_n = 1'b0;
    #1;
    $display("reset asserted mid-line");
    check_idle("midline_reset");
    lens.delete();
    armed = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int x = 0; x < 5; x++) lcd_cycle(1'b1, HS_OFF, VS_OFF, 16'($urandom));
    repeat (2) lcd_cycle(1'b0, HS_OFF, VS_OFF, 16'h0);
    send_line(8, 2, 1'b0, 1'b0);
    send_vs(2);
    chk("meas_valid_after_reset", meas_valid, 0);
    for (int l = 0; l < 3; l++) send_line(5, 2, 1'b1, 1'b0);
    send_vs(1);

    repeat (30) @(negedge sys_clk);
    chk("pix_queue_empty", pix_q.size(), 0);
    chk("close_queue_empty", close_q.size(), 0);
    chk("line_end_count", le_seen, le_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_rgb_rx.md
# lcd_rgb_rx

Panel-side receiver for the 16-bit parallel RGB LCD interface (lcd_clk, lcd_de, lcd_hs, lcd_vs, lcd_rgb) that our LCD character/pattern drivers produce. It oversamples the interface on the system clock and turns it into a pixel stream with x/y coordinates and frame/line markers. It measures the active resolution per frame, flags malformed frames, and answers the driver's ID read by presenting an ID word while DE is low. It is used as a loop-back checker in simulation and in FPGA self-test builds.

## Interface
- X_W, 11, width of pixel x counter and h_active
- Y_W, 11, width of line y counter and v_active
- SYNC_POL, 1'b0, active level of lcd_hs and lcd_vs (0 = active-low)
- PANEL_ID, 16'h0010, word driven on lcd_rgb_id while DE is low
- sys_clk  in  1  system clock; must be at least 4x the lcd_clk frequency
- sys_rst_n  in  1  asynchronous active-low reset
- lcd_clk  in  1  pixel clock from driver, sampled as data
- lcd_de, lcd_hs, lcd_vs  in  1 each  data enable, line sync, frame sync
- lcd_rgb_in  in  16  RGB565 pixel bus
- lcd_rgb_id_oe  out  1  ID drive enable toward the pad tristate
- lcd_rgb_id  out  16  constant PANEL_ID
- pix_valid  out  1  one-cycle strobe per captured active pixel
- pix_data  out  16  captured pixel
- pix_x  out  X_W  column of pix_data
- pix_y  out  Y_W  row of pix_data
- frame_start  out  1  pulse coincident with pixel (0,0)
- line_end  out  1  pulse when DE deasserts
- frame_done  out  1  pulse at frame-closing VS assertion
- h_active  out  X_W  pixels per line of last completed frame
- v_active  out  Y_W  lines of last completed frame
- meas_valid  out  1  set at first frame_done; cleared only by reset
- err_line_len  out  1  last completed frame had unequal line lengths or counter saturation

## Operation
- Synchronization: lcd_clk, lcd_de, lcd_hs, lcd_vs and lcd_rgb_in each pass through identical 2-flop synchronizers, so all are equally delayed. A sample event occurs when the synchronized lcd_clk is 1 and was 0 on the previous cycle. All decoding below acts only on sample events.
- Sync detection: hs_act = (hs == SYNC_POL), and likewise vs_act. A VS edge is a sample event where vs_act is true and was false on the previous sample.
- FSM states:
  - WAIT_VS (reset): ignore everything until the first VS edge, then go to V_BLANK.
  - V_BLANK: on DE high, go to ACTIVE.
  - ACTIVE: emit a pixel per sample. On DE low, emit line_end, increment y, go to H_BLANK.
  - H_BLANK: on DE high, go to ACTIVE. On VS edge, close the frame and go to V_BLANK.
  - Any state except WAIT_VS also closes the frame on a VS edge.
- Pixel emit: pix_data is the sampled RGB, pix_x = x, pix_y = y. x increments after each pixel and returns to 0 on line_end.
- Saturation: x saturates at 2^X_W-1 and y saturates at 2^Y_W-1; either saturation sets a pending error.
- Line length check: the first line_end of a frame stores ref_len = x. Any later line_end with x != ref_len sets the pending error.
- Frame close:
  - frame_done pulses.
  - v_active takes y (the completed lines) and h_active takes ref_len.
  - err_line_len takes the pending error.
  - meas_valid is set, then x, y and the pending error are cleared.
- Frame close in ACTIVE (VS edge while DE high): line_end and frame_done fire in the same cycle, the partial line counts toward y, and the pending error is set before it is transferred.
- Frame with no DE: v_active = 0 and h_active = 0.
- ID: lcd_rgb_id_oe is a single register of ~lcd_de taken straight from the pin, not synchronized, with 1 cycle of delay. lcd_rgb_id is the constant PANEL_ID.

## Timing
- Reset values:
  - All pulse outputs: 0.
  - pix_data, pix_x, pix_y, h_active, v_active: 0.
  - meas_valid, err_line_len, lcd_rgb_id_oe: 0.
  - FSM: WAIT_VS.
- Latency: from the lcd_clk rising edge at the pin, pix_valid asserts 4 sys_clk cycles later (2 sync + 1 edge + 1 output register). All outputs are registered.
- Sampling requirement: the driver holds de/hs/vs/rgb stable for at least 2 sys_clk cycles on each side of the lcd_clk rising edge.
- Reset assertion mid-frame clears everything immediately. The next frame is ignored until a VS edge.

## Test plan
- 8x4 active frame (HBP 3, VBP 2), pixel = {y,x}, lcd_clk = sys_clk/4 → 32 pix_valid pulses in raster order, frame_start at (0,0), 4 line_end pulses; at the second VS edge, h_active=8, v_active=4, meas_valid=1, err_line_len=0.
- Stimulus begins mid-frame after reset → no pix_valid until the first VS edge; first frame_done reports only the complete frame.
- Line 2 of a 4-line frame is 7 pixels wide → err_line_len=1, h_active=8; the next clean frame returns err_line_len to 0.
- VS edge while DE is high after 5 pixels → line_end and frame_done in the same cycle, err_line_len=1.
- lcd_de toggling → lcd_rgb_id_oe follows ~lcd_de one cycle later, lcd_rgb_id=16'h0010; sys_rst_n pulsed low mid-line → all outputs 0 and WAIT_VS behaviour resumes.
